// File: rtl/msrv32_seq_alu.sv
// rtl/msrv32_seq_alu.sv - handshaked RV32I ALU with iterative shifter
// Define MSRV32_SEQ_ALU_FAST_SHIFT_EN for a single-cycle barrel shifter instead.
module msrv32_seq_alu #(
    parameter int XLEN       = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_n_in,
    input  logic            flush_in,
    input  logic            valid_in,
    output logic            ready_out,
    input  logic [XLEN-1:0] op_1_in,
    input  logic [XLEN-1:0] op_2_in,
    input  logic [3:0]      opcode_in,
    output logic            valid_out,
    input  logic            ready_in,
    output logic [XLEN-1:0] result_out,
    output logic            illegal_out
);
    localparam int SHW = $clog2(XLEN);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b0010;
    localparam logic [3:0] OP_SLTU = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0111;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SRL  = 4'b0101;
    localparam logic [3:0] OP_SRA  = 4'b1101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            illegal_q, illegal_d;

    logic            accept;
    logic            is_shift;
    logic            is_illegal;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] first_shift;
    logic [XLEN-1:0] alu_res;

    // Shift kind is opcode[3:2]: 00 SLL, 01 SRL, 11 SRA.
    function automatic logic [XLEN-1:0] shift_by(input logic [XLEN-1:0] v,
                                                 input logic [SHW-1:0]  amt,
                                                 input logic [1:0]      kind);
        logic [XLEN-1:0] r;
        case (kind)
            2'b00:   r = v << amt;
            2'b11:   r = $signed(v) >>> amt;
            default: r = v >> amt;
        endcase
        return r;
    endfunction

    assign shamt    = op_2_in[SHW-1:0];
    assign is_shift = (opcode_in == OP_SLL) || (opcode_in == OP_SRL) || (opcode_in == OP_SRA);

`ifdef MSRV32_SEQ_ALU_FAST_SHIFT_EN
    assign first_shift = shift_by(op_1_in, shamt, opcode_in[3:2]);
`else
    localparam logic [SHW-1:0] STEP_W = SHW'(SHIFT_STEP);

    logic [XLEN-1:0] work_q, work_d;
    logic [SHW-1:0]  rem_q, rem_d;
    logic [1:0]      kind_q, kind_d;
    logic [SHW-1:0]  first_amt;
    logic [SHW-1:0]  first_rest;
    logic [SHW-1:0]  iter_amt;

    // The first step happens on the accept edge so latency is ceil(shamt/STEP).
    assign first_amt   = (shamt > STEP_W) ? STEP_W : shamt;
    assign first_rest  = shamt - first_amt;
    assign first_shift = shift_by(op_1_in, first_amt, opcode_in[3:2]);
    assign iter_amt    = (rem_q > STEP_W) ? STEP_W : rem_q;
`endif

    always_comb begin
        alu_res    = '0;
        is_illegal = 1'b0;
        case (opcode_in)
            OP_ADD:  alu_res = op_1_in + op_2_in;
            OP_SUB:  alu_res = op_1_in - op_2_in;
            OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op_1_in) < $signed(op_2_in)};
            OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op_1_in < op_2_in};
            OP_AND:  alu_res = op_1_in & op_2_in;
            OP_OR:   alu_res = op_1_in | op_2_in;
            OP_XOR:  alu_res = op_1_in ^ op_2_in;
            OP_SLL, OP_SRL, OP_SRA: alu_res = first_shift;
            default: is_illegal = 1'b1;
        endcase
    end

    assign ready_out = ms_riscv32_mp_rst_n_in && !flush_in &&
                       ((state_q == IDLE) || ((state_q == DONE) && ready_in));
    assign accept    = valid_in && ready_out;

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        illegal_d = illegal_q;
`ifndef MSRV32_SEQ_ALU_FAST_SHIFT_EN
        work_d    = work_q;
        rem_d     = rem_q;
        kind_d    = kind_q;
`endif
        if (flush_in) begin
            state_d = IDLE;
        end else if (accept) begin
`ifndef MSRV32_SEQ_ALU_FAST_SHIFT_EN
            if (is_shift && (first_rest != '0)) begin
                state_d = SHIFT;
                work_d  = first_shift;
                rem_d   = first_rest;
                kind_d  = opcode_in[3:2];
            end else
`endif
            begin
                state_d   = DONE;
                illegal_d = is_illegal;
                result_d  = is_illegal ? '0 : alu_res;
            end
        end else begin
            case (state_q)
`ifndef MSRV32_SEQ_ALU_FAST_SHIFT_EN
                SHIFT: begin
                    work_d = shift_by(work_q, iter_amt, kind_q);
                    rem_d  = rem_q - iter_amt;
                    if (rem_d == '0) begin
                        state_d   = DONE;
                        result_d  = work_d;
                        illegal_d = 1'b0;
                    end
                end
`endif
                DONE: if (ready_in) state_d = IDLE;
                default: ;
            endcase
        end
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q   <= IDLE;
            result_q  <= '0;
            illegal_q <= 1'b0;
`ifndef MSRV32_SEQ_ALU_FAST_SHIFT_EN
            work_q    <= '0;
            rem_q     <= '0;
            kind_q    <= 2'b00;
`endif
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
`ifndef MSRV32_SEQ_ALU_FAST_SHIFT_EN
            work_q    <= work_d;
            rem_q     <= rem_d;
            kind_q    <= kind_d;
`endif
        end
    end

    assign valid_out   = (state_q == DONE);
    assign result_out  = result_q;
    assign illegal_out = illegal_q;
endmodule

// File: tb/tb_msrv32_seq_alu.sv
// tb/tb_msrv32_seq_alu.sv - self-checking bench for msrv32_seq_alu
module tb_msrv32_seq_alu;
    localparam int XLEN = 32;
    localparam int STEP = 1;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush_in;
    logic            valid_in;
    logic            ready_out;
    logic [XLEN-1:0] op_1_in;
    logic [XLEN-1:0] op_2_in;
    logic [3:0]      opcode_in;
    logic            valid_out;
    logic            ready_in;
    logic [XLEN-1:0] result_out;
    logic            illegal_out;

    int tests = 0;
    int fails = 0;

    msrv32_seq_alu #(.XLEN(XLEN), .SHIFT_STEP(STEP)) dut (
        .ms_riscv32_mp_clk_in   (clk),
        .ms_riscv32_mp_rst_n_in (rst_n),
        .flush_in               (flush_in),
        .valid_in               (valid_in),
        .ready_out              (ready_out),
        .op_1_in                (op_1_in),
        .op_2_in                (op_2_in),
        .opcode_in              (opcode_in),
        .valid_out              (valid_out),
        .ready_in               (ready_in),
        .result_out             (result_out),
        .illegal_out            (illegal_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int exp_latency(input int sh);
`ifdef MSRV32_SEQ_ALU_FAST_SHIFT_EN
        return 1;
`else
        return (sh == 0) ? 1 : (sh + STEP - 1) / STEP;
`endif
    endfunction

    // Reference model: RV32I semantics directly from the opcode table.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ill, output int lat);
        int sh;
        sh  = int'(b[4:0]);
        ill = 1'b0;
        lat = 1;
        r   = 32'h0;
        case (op)
            4'b0000: r = a + b;
            4'b1000: r = a - b;
            4'b0010: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b0011: r = (a < b) ? 32'd1 : 32'd0;
            4'b0111: r = a & b;
            4'b0110: r = a | b;
            4'b0100: r = a ^ b;
            4'b0001: begin r = a << sh; lat = exp_latency(sh); end
            4'b0101: begin r = a >> sh; lat = exp_latency(sh); end
            4'b1101: begin r = $unsigned($signed(a) >>> sh); lat = exp_latency(sh); end
            default: ill = 1'b1;
        endcase
    endfunction

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ei, input int el);
        int n;
        bit done;
        @(negedge clk);
        check({name, ".ready"}, {31'd0, ready_out}, 32'd1);
        valid_in  = 1'b1;
        opcode_in = op;
        op_1_in   = a;
        op_2_in   = b;
        ready_in  = 1'b1;
        @(posedge clk);
        #1;
        valid_in  = 1'b0;
        op_1_in   = $urandom;
        op_2_in   = $urandom;
        n = 0;
        done = 1'b0;
        while (!done && n < 64) begin
            @(negedge clk);
            n++;
            if (valid_out) done = 1'b1;
        end
        check({name, ".latency"}, n, el);
        check({name, ".result"}, result_out, er);
        check({name, ".illegal"}, {31'd0, illegal_out}, {31'd0, ei});
    endtask

    vec_t vecs[$];
    logic [3:0] legal_ops[10] = '{4'b0000, 4'b1000, 4'b0010, 4'b0011, 4'b0111,
                                  4'b0110, 4'b0100, 4'b0001, 4'b0101, 4'b1101};
    logic [3:0] bad_ops[6] = '{4'b1001, 4'b1010, 4'b1011, 4'b1100, 4'b1110, 4'b1111};

    initial begin
        logic [31:0] r;
        logic        ill;
        int          lat;
        int          seen;
        logic [3:0]  op;
        logic [31:0] a, b;

        rst_n = 1'b0; flush_in = 1'b0; valid_in = 1'b0; ready_in = 1'b0;
        op_1_in = '0; op_2_in = '0; opcode_in = '0;

        @(negedge clk);
        check("reset.ready_out", {31'd0, ready_out}, 32'd0);
        @(negedge clk);
        check("reset.valid_out", {31'd0, valid_out}, 32'd0);
        check("reset.result", result_out, 32'd0);
        check("reset.illegal", {31'd0, illegal_out}, 32'd0);
        rst_n = 1'b1;

        vecs.push_back('{4'b0000, 32'h7FFFFFFF, 32'h1,  32'h80000000, 1'b0, 1});
        vecs.push_back('{4'b0010, 32'hFFFFFFFF, 32'h1,  32'h1,        1'b0, 1});
        vecs.push_back('{4'b0011, 32'hFFFFFFFF, 32'h1,  32'h0,        1'b0, 1});
        vecs.push_back('{4'b1101, 32'h80000000, 32'h4,  32'hF8000000, 1'b0, exp_latency(4)});
        vecs.push_back('{4'b0001, 32'h1,        32'h21, 32'h2,        1'b0, 1});
        vecs.push_back('{4'b0101, 32'hDEADBEEF, 32'h20, 32'hDEADBEEF, 1'b0, 1});
        vecs.push_back('{4'b1111, 32'h12345678, 32'h9,  32'h0,        1'b1, 1});
        vecs.push_back('{4'b1000, 32'h0,        32'h1,  32'hFFFFFFFF, 1'b0, 1});
        vecs.push_back('{4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1});
        vecs.push_back('{4'b1101, 32'h80000000, 32'h1F, 32'hFFFFFFFF, 1'b0, exp_latency(31)});
        for (int i = 0; i < vecs.size(); i++)
            run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                   vecs[i].res, vecs[i].ill, vecs[i].lat);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 5)];
            else                           op = legal_ops[$urandom_range(0, 9)];
            a = $urandom;
            b = $urandom;
            model(op, a, b, r, ill, lat);
            run_op($sformatf("rand%0d_op%b", i, op), op, a, b, r, ill, lat);
        end

        // Stall in DONE, then back-to-back ADDs at one result per cycle.
        @(negedge clk);
        ready_in = 1'b0; valid_in = 1'b1; opcode_in = 4'b0000; op_1_in = 32'd5; op_2_in = 32'd6;
        @(posedge clk);
        #1 valid_in = 1'b0; op_1_in = 32'hAAAA5555;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("stall%0d.valid", k), {31'd0, valid_out}, 32'd1);
            check($sformatf("stall%0d.result", k), result_out, 32'd11);
            if (k > 0) check($sformatf("stall%0d.ready_out", k), {31'd0, ready_out}, 32'd0);
        end
        ready_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            valid_in = 1'b1; opcode_in = 4'b0000; op_1_in = k; op_2_in = 32'd100;
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b2b%0d.valid", k), {31'd0, valid_out}, 32'd1);
            check($sformatf("b2b%0d.result", k), result_out, 32'd100 + k);
        end
        valid_in = 1'b0;
        @(negedge clk);
        check("b2b.drain", {31'd0, valid_out}, 32'd0);

        // Flush during a long SRL; the op arriving in the flush cycle is dropped.
        valid_in = 1'b1; opcode_in = 4'b0101; op_1_in = 32'hFFFFFFFF; op_2_in = 32'd31;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (9) @(negedge clk);
        flush_in = 1'b1; valid_in = 1'b1; opcode_in = 4'b0000; op_1_in = 32'd1; op_2_in = 32'd1;
        check("flush.ready_out", {31'd0, ready_out}, 32'd0);
        @(posedge clk);
        #1 flush_in = 1'b0; valid_in = 1'b0;
        @(negedge clk);
        check("flush.valid", {31'd0, valid_out}, 32'd0);
        check("flush.idle", {31'd0, ready_out}, 32'd1);
        check("flush.result_kept", result_out, 32'd103);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("flush.no_valid", seen, 0);

        // Reset in the middle of a shift: no partial result may surface.
        valid_in = 1'b1; opcode_in = 4'b1101; op_1_in = 32'h80000000; op_2_in = 32'd20;
        @(posedge clk);
        #1 valid_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1 check("rst_mid.ready_out", {31'd0, ready_out}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid.result", result_out, 32'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (valid_out) seen++;
        end
        check("rst_mid.no_valid", seen, 0);

        run_op("post_reset_add", 4'b0000, 32'd40, 32'd2, 32'd42, 1'b0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
